// File: rtl/rr_reg_arbiter.sv
// Round-robin owner of one shared W-bit register among N requesters.
// The owner's data slice is loaded each owned cycle; lock extends ownership.
module rr_reg_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int OW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [OW-1:0]  owner,
  output logic [W-1:0]   q,
  output logic           q_valid,
  output logic           dbg_state
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [W-1:0]  q_q, q_d;
  logic          q_valid_q, q_valid_d;

  logic [OW-1:0] win;
  logic [OW-1:0] cand;

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    win  = ptr_q;
    cand = ptr_q;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr_q + OW'(k);
      if (req[cand]) win = cand;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    q_d       = q_q;
    q_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|req) begin
          gnt_d[win] = 1'b1;
          owner_d    = win;
          q_d        = wdata[win*W +: W];
          q_valid_d  = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (req[owner_q] && lock[owner_q]) begin
          q_d       = wdata[owner_q*W +: W];
          q_valid_d = 1'b1;
        end else begin
          gnt_d   = '0;
          ptr_d   = owner_q + OW'(1);
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      owner_q   <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign q         = q_q;
  assign q_valid   = q_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: directed scenarios plus random traffic against
// an arithmetic ownership model; req/lock/wdata are sampled on the rising edge.
module tb_rr_reg_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int OW = $clog2(N);

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [OW-1:0]  owner;
  logic [W-1:0]   q;
  logic           q_valid;
  logic           dbg_state;

  rr_reg_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .owner(owner), .q(q), .q_valid(q_valid), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference model: who owns the register and where the next search starts
  bit           m_busy;
  int           m_owner;
  int           m_ptr;
  logic [W-1:0] m_q;
  bit           m_qv;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] slice(input logic [N*W-1:0] d, input int i);
    return d[i*W +: W];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_q = '0; m_qv = 0;
    exp_q.push_back(m_q);
  endtask

  task automatic model_update();
    int w;
    if (!m_busy) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_q = slice(wdata, w); m_qv = 1;
      end else begin
        m_qv = 0;
      end
    end else if (req[m_owner] && lock[m_owner]) begin
      m_q = slice(wdata, m_owner); m_qv = 1;
    end else begin
      m_busy = 0; m_qv = 0; m_ptr = (m_owner + 1) % N;
    end
    exp_q.push_back(m_q);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // scoreboard: compare every output against the model
  task automatic check_outputs();
    logic [N-1:0] e_gnt;
    logic [W-1:0] e_q;
    e_gnt = '0;
    if (m_busy) e_gnt[m_owner] = 1'b1;
    e_q = (exp_q.size() > 0) ? exp_q.pop_front() : ~m_q;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("q", 32'(q), 32'(e_q));
    chk("q_valid", 32'(q_valid), 32'(m_qv));
    chk("state", 32'(dbg_state), 32'(m_busy));
  endtask

  // driver: apply inputs now, take one rising edge, check 1ns later
  task automatic drive_cycle(input logic [N-1:0] r, input logic [N-1:0] l,
                             input logic [N*W-1:0] d);
    req = r; lock = l; wdata = d;
    @(posedge clk);
    if (rst) model_update();
    #1;
    check_outputs();
  endtask

  // asynchronous reset mid-cycle, held over two edges, released mid-cycle
  task automatic async_reset();
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    for (int i = 0; i < 2; i++) begin
      req = N'($urandom); lock = N'($urandom);
      for (int j = 0; j < N; j++) wdata[j*W +: W] = W'($urandom);
      @(posedge clk);
      #1;
      exp_q.push_back(m_q);
      check_outputs();
    end
    #3;
    rst = 1'b1;
  endtask

  logic [N*W-1:0] d;

  initial begin
    rst = 1'b1; req = '0; lock = '0; wdata = '0;
    @(posedge clk); #1;

    // reset and idle
    async_reset();
    for (int i = 0; i < 3; i++) drive_cycle('0, '0, '0);
    chk("idle_q_zero", 32'(q), 32'h0);

    // single request
    d = '0; d[2*W +: W] = 8'hA5;
    drive_cycle(4'b0100, 4'b0000, d);
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_q", 32'(q), 32'hA5);
    drive_cycle(4'b0000, 4'b0000, d);
    chk("single_release_q", 32'(q), 32'hA5);
    chk("single_release_gnt", 32'(gnt), 32'h0);

    // round robin with all requesting, including wrap 3 -> 0
    async_reset();
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < N; j++) d[j*W +: W] = W'(8'h10 * (j + 1) + i);
      drive_cycle(4'b1111, 4'b0000, d);
      if (i % 2 == 0) chk("rr_gnt", 32'(gnt), 32'(1 << ((i / 2) % N)));
      else chk("rr_bubble", 32'(gnt), 32'h0);
    end

    // lock hold by requester 1 with requester 3 waiting
    async_reset();
    d = '0;
    drive_cycle(4'b0010, 4'b0010, d);
    for (int i = 1; i <= 4; i++) begin
      d[1*W +: W] = W'(i);
      drive_cycle(4'b1010, 4'b0010, d);
      chk("lock_gnt", 32'(gnt), 32'h2);
      chk("lock_q", 32'(q), 32'(i));
    end
    drive_cycle(4'b1010, 4'b0000, d);
    chk("lock_release", 32'(gnt), 32'h0);
    drive_cycle(4'b1000, 4'b0000, d);
    chk("lock_next_owner", 32'(owner), 32'h3);

    // lock from a non-owner is ignored
    async_reset();
    d = '0; d[0*W +: W] = 8'h11; d[2*W +: W] = 8'h22;
    drive_cycle(4'b0101, 4'b0100, d);
    chk("nonowner_first", 32'(owner), 32'h0);
    drive_cycle(4'b0100, 4'b0100, d);
    chk("nonowner_release", 32'(gnt), 32'h0);
    drive_cycle(4'b0100, 4'b0100, d);
    chk("nonowner_grant", 32'(gnt), 32'h4);
    drive_cycle(4'b0100, 4'b0100, d);
    chk("nonowner_locked", 32'(gnt), 32'h4);
    drive_cycle(4'b0000, 4'b0000, d);

    // reset while requester 3 holds a lock
    async_reset();
    d = '0; d[3*W +: W] = 8'h33; d[0*W +: W] = 8'h44;
    drive_cycle(4'b1000, 4'b1000, d);
    drive_cycle(4'b1000, 4'b1000, d);
    chk("midlock_q", 32'(q), 32'h33);
    async_reset();
    chk("midlock_gnt", 32'(gnt), 32'h0);
    drive_cycle(4'b1001, 4'b0000, d);
    chk("midlock_after", 32'(owner), 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < N; j++) d[j*W +: W] = W'($urandom);
      drive_cycle(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)), d);
      if ($urandom_range(0, 63) == 0) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
